mem_req_scheduler: RTL

MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

---
 rtl/mem_req_scheduler.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_req_scheduler.sv
// Arbitrates dcache, icache and next-line prefetch line requests onto one
// cacheline adaptor port. An icache starvation counter bounds dcache bursts.
module mem_req_scheduler #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         dcache_pmem_read,
    input  logic         dcache_pmem_write,
    input  logic [31:0]  dcache_pmem_address,
    input  logic [255:0] dcache_pmem_wdata,
    output logic [255:0] dcache_pmem_rdata,
    output logic         dcache_pmem_resp,
    input  logic         icache_pmem_read,
    input  logic [31:0]  icache_pmem_address,
    output logic [255:0] icache_pmem_rdata,
    output logic         icache_pmem_resp,
    input  logic         pf_read,
    input  logic [31:0]  pf_address,
    output logic [255:0] pf_rdata,
    output logic         pf_resp,
    output logic         line_read,
    output logic         line_write,
    output logic [31:0]  line_address,
    output logic [255:0] line_wdata,
    input  logic [255:0] line_rdata,
    input  logic         line_resp,
    output logic         busy
);
    localparam logic [3:0]  LIMIT     = STARVE_LIMIT[3:0];
    localparam logic [31:0] LINE_MASK = ~32'h1F;

    typedef enum logic [2:0] {IDLE, SRV_D, SRV_I, SRV_P, DONE} state_e;

    state_e         state_q, state_d;
    logic [3:0]     starve_q, starve_d;
    logic           line_read_q, line_read_d;
    logic           line_write_q, line_write_d;
    logic [31:0]    line_addr_q, line_addr_d;
    logic [255:0]   line_wdata_q, line_wdata_d;

    logic d_req, force_i;
    assign d_req   = dcache_pmem_read | dcache_pmem_write;
    assign force_i = icache_pmem_read && (starve_q == LIMIT);

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        line_read_d  = line_read_q;
        line_write_d = line_write_q;
        line_addr_d  = line_addr_q;
        line_wdata_d = line_wdata_q;
        case (state_q)
            IDLE: begin
                if (d_req && !force_i) begin
                    // Write wins when both dcache strobes are high.
                    state_d      = SRV_D;
                    line_addr_d  = dcache_pmem_address & LINE_MASK;
                    line_write_d = dcache_pmem_write;
                    line_read_d  = !dcache_pmem_write;
                    line_wdata_d = dcache_pmem_write ? dcache_pmem_wdata : '0;
                    if (icache_pmem_read && (starve_q < LIMIT))
                        starve_d = starve_q + 4'd1;
                end else if (icache_pmem_read) begin
                    state_d      = SRV_I;
                    line_addr_d  = icache_pmem_address & LINE_MASK;
                    line_read_d  = 1'b1;
                    line_write_d = 1'b0;
                    line_wdata_d = '0;
                    starve_d     = '0;
                end else if (pf_read) begin
                    state_d      = SRV_P;
                    line_addr_d  = pf_address & LINE_MASK;
                    line_read_d  = 1'b1;
                    line_write_d = 1'b0;
                    line_wdata_d = '0;
                end
            end
            SRV_D, SRV_I, SRV_P: begin
                if (line_resp) begin
                    state_d      = DONE;
                    line_read_d  = 1'b0;
                    line_write_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            line_read_q  <= 1'b0;
            line_write_q <= 1'b0;
            line_addr_q  <= '0;
            line_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            line_read_q  <= line_read_d;
            line_write_q <= line_write_d;
            line_addr_q  <= line_addr_d;
            line_wdata_q <= line_wdata_d;
        end
    end

    assign line_read    = line_read_q;
    assign line_write   = line_write_q;
    assign line_address = line_addr_q;
    assign line_wdata   = line_wdata_q;
    assign busy         = (state_q != IDLE);

    assign dcache_pmem_rdata = line_rdata;
    assign icache_pmem_rdata = line_rdata;
    assign pf_rdata          = line_rdata;

    // Responses pass straight through only for the requester being served.
    assign dcache_pmem_resp = (state_q == SRV_D) && line_resp;
    assign icache_pmem_resp = (state_q == SRV_I) && line_resp;
    assign pf_resp          = (state_q == SRV_P) && line_resp;
endmodule
